// File: rtl/bmp_stream_parser.sv
// bmp_stream_parser: decodes and validates the 54-byte BMP header arriving as
// 32-bit words, drops header/extension/palette bytes and forwards the pixel
// array realigned onto word boundaries over a valid/ready output port.
//
// Handshake: a word moves on in_* (or out_*) only in a cycle where both valid
// and ready are high at posedge clk; a producer holds data stable while
// valid is high and ready is low.
module bmp_stream_parser #(
    parameter int DATA_WIDTH    = 32,
    parameter int HDR_BYTES     = 54,
    parameter int MAX_FILE_SIZE = 1000000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last,
    output logic [2:0]            out_nbytes,
    output logic [31:0]           file_size,
    output logic [31:0]           data_offset,
    output logic [31:0]           img_width,
    output logic [31:0]           img_height,
    output logic [15:0]           bit_count,
    output logic                  hdr_valid,
    output logic                  hdr_err,
    output logic                  done
);

    typedef enum logic [2:0] {IDLE, HEADER, SKIP, PAYLOAD, FLUSH, DONE, ERROR} state_t;

    // Byte position of the first byte of the word holding the last header byte.
    localparam logic [31:0] HDR_LAST_POS = 32'((HDR_BYTES - 1) / 4 * 4);

    state_t      state, next_state, after_ingest;
    logic [31:0] byte_cnt, next_cnt;
    logic [31:0] stage_data;      // leftover bytes, MSB-aligned, unused lanes zero
    logic [2:0]  stage_cnt;
    logic [63:0] comb_data;       // leftover bytes followed by this word's payload bytes
    logic [2:0]  comb_cnt, rem_cnt;
    logic        in_fire, out_fire, out_free;
    logic        sig_ok, hdr_ok, hdr_last_word, is_final, ingest, emit, start_accept;

    assign in_fire       = in_valid && in_ready;
    assign out_fire      = out_valid && out_ready;
    assign out_free      = !out_valid || out_ready;
    assign next_cnt      = byte_cnt + 32'd4;
    assign is_final      = next_cnt >= file_size;
    assign hdr_last_word = byte_cnt == HDR_LAST_POS;
    assign sig_ok        = (in_data[31:24] == 8'h42) && (in_data[23:16] == 8'h4D);
    assign hdr_ok        = (bit_count == 16'd8 || bit_count == 16'd24 || bit_count == 16'd32)
                        && (img_width != 32'd0) && (img_height != 32'd0)
                        && (data_offset >= 32'(HDR_BYTES)) && (data_offset < file_size)
                        && (file_size <= 32'(MAX_FILE_SIZE));
    assign start_accept  = start && (state == IDLE || state == DONE || state == ERROR);
    // Header word 13 only contributes payload bytes if the header is good.
    assign ingest        = in_fire && (state == SKIP || state == PAYLOAD ||
                                       (state == HEADER && hdr_last_word && hdr_ok));
    // in_ready already implies a free output register, so no stall term here.
    assign emit          = ingest && (comb_cnt >= 3'd4);
    assign rem_cnt       = emit ? comb_cnt - 3'd4 : comb_cnt;

    // Append the in-range bytes of the current word (data_offset <= pos < file_size).
    always_comb begin
        logic [31:0] pos;
        pos       = '0;
        comb_data = {stage_data, 32'h0};
        comb_cnt  = stage_cnt;
        for (int i = 0; i < 4; i++) begin
            pos = byte_cnt + 32'(i);
            if (ingest && pos >= data_offset && pos < file_size) begin
                comb_data[63 - 8*int'(comb_cnt) -: 8] = in_data[31 - 8*i -: 8];
                comb_cnt = comb_cnt + 3'd1;
            end
        end
    end

    // Where to go after a word that carried (or could carry) payload bytes.
    always_comb begin
        after_ingest = SKIP;
        if (is_final)
            after_ingest = (rem_cnt == 3'd0) ? PAYLOAD : FLUSH;
        else if (next_cnt > data_offset)
            after_ingest = PAYLOAD;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    // Next-state and in_ready decode.
    always_comb begin
        next_state = state;
        in_ready   = 1'b0;
        case (state)
            IDLE, DONE, ERROR: if (start) next_state = HEADER;
            HEADER: begin
                in_ready = 1'b1;
                if (in_fire) begin
                    if (byte_cnt == 32'd0 && !sig_ok) next_state = ERROR;
                    else if (hdr_last_word)           next_state = hdr_ok ? after_ingest : ERROR;
                end
            end
            SKIP: begin
                in_ready = 1'b1;
                if (in_fire) next_state = after_ingest;
            end
            PAYLOAD: begin
                // Once byte_cnt reaches file_size we only wait for the last word to leave.
                in_ready = out_free && (byte_cnt < file_size);
                if (in_fire)                   next_state = after_ingest;
                else if (out_fire && out_last) next_state = DONE;
            end
            FLUSH:   if (out_fire && out_last) next_state = DONE;
            default: next_state = IDLE;
        endcase
    end

    // Byte counter, header capture, staging buffer, output register and status flags.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            byte_cnt    <= '0;
            stage_data  <= '0;
            stage_cnt   <= '0;
            out_data    <= '0;
            out_valid   <= 1'b0;
            out_last    <= 1'b0;
            out_nbytes  <= '0;
            file_size   <= '0;
            data_offset <= '0;
            img_width   <= '0;
            img_height  <= '0;
            bit_count   <= '0;
            hdr_valid   <= 1'b0;
            hdr_err     <= 1'b0;
            done        <= 1'b0;
        end else begin
            if (start_accept) begin
                byte_cnt   <= '0;
                stage_data <= '0;
                stage_cnt  <= '0;
                hdr_valid  <= 1'b0;
                hdr_err    <= 1'b0;
                done       <= 1'b0;
            end
            if (in_fire) begin
                byte_cnt   <= next_cnt;
                stage_data <= emit ? comb_data[31:0] : comb_data[63:32];
                stage_cnt  <= rem_cnt;
            end
            if (in_fire && state == HEADER) begin
                // Little-endian fields picked out of the word by file byte position.
                case (byte_cnt[7:2])
                    6'd0: file_size[15:0]    <= {in_data[7:0],   in_data[15:8]};
                    6'd1: file_size[31:16]   <= {in_data[23:16], in_data[31:24]};
                    6'd2: data_offset[15:0]  <= {in_data[7:0],   in_data[15:8]};
                    6'd3: data_offset[31:16] <= {in_data[23:16], in_data[31:24]};
                    6'd4: img_width[15:0]    <= {in_data[7:0],   in_data[15:8]};
                    6'd5: begin
                        img_width[31:16]     <= {in_data[23:16], in_data[31:24]};
                        img_height[15:0]     <= {in_data[7:0],   in_data[15:8]};
                    end
                    6'd6: img_height[31:16]  <= {in_data[23:16], in_data[31:24]};
                    6'd7: bit_count          <= {in_data[23:16], in_data[31:24]};
                    default: ;
                endcase
                if (byte_cnt == 32'd0 && !sig_ok) hdr_err <= 1'b1;
                else if (hdr_last_word) begin
                    if (hdr_ok) hdr_valid <= 1'b1;
                    else        hdr_err   <= 1'b1;
                end
            end
            if (emit) begin
                out_valid  <= 1'b1;
                out_data   <= comb_data[63:32];
                out_last   <= is_final && (comb_cnt == 3'd4);
                out_nbytes <= 3'd4;
            end else if (state == FLUSH && out_free && stage_cnt != 3'd0) begin
                out_valid  <= 1'b1;
                out_data   <= stage_data;
                out_last   <= 1'b1;
                out_nbytes <= stage_cnt;
                stage_data <= '0;
                stage_cnt  <= '0;
            end else if (out_fire) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end
            if (out_fire && out_last) done <= 1'b1;
        end
    end

endmodule

// File: tb/tb_bmp_stream_parser.sv
// Directed bench for bmp_stream_parser: builds small BMP files byte by byte,
// streams them in and scores every output word against an expected queue.
module tb_bmp_stream_parser;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic        out_last;
    logic [2:0]  out_nbytes;
    logic [31:0] file_size, data_offset, img_width, img_height;
    logic [15:0] bit_count;
    logic        hdr_valid, hdr_err, done;

    int          n_checks = 0;
    int          n_fail = 0;
    logic [7:0]  fb [0:255];
    logic [31:0] words [0:63];
    int          n_words;
    logic [35:0] exp_q[$];     // {last, nbytes, data}
    int          n_out;
    int          valid_seen;
    logic [31:0] first_data, last_data;
    logic [2:0]  last_nb;
    logic        ready_toggle = 1'b0;
    logic        prev_stall = 1'b0;
    logic [35:0] prev_word;

    bmp_stream_parser dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_last(out_last), .out_nbytes(out_nbytes),
        .file_size(file_size), .data_offset(data_offset),
        .img_width(img_width), .img_height(img_height), .bit_count(bit_count),
        .hdr_valid(hdr_valid), .hdr_err(hdr_err), .done(done)
    );

    // Clock and watchdog.
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(string tag, logic [63:0] got, logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic put32(int at, int v);
        for (int i = 0; i < 4; i++) fb[at+i] = 8'(v >> (8*i));
    endtask

    // Header bytes plus payload pattern byte[i] = i.
    task automatic build_hdr(int fsize, int doff, int w, int h, int bc);
        for (int i = 0; i < 256; i++) fb[i] = (i < 54) ? 8'h00 : 8'(i);
        fb[0] = 8'h42;
        fb[1] = 8'h4D;
        put32(2, fsize);
        put32(10, doff);
        put32(14, 40);
        put32(18, w);
        put32(22, h);
        fb[26] = 8'd1;
        fb[28] = 8'(bc);
        fb[29] = 8'(bc >> 8);
    endtask

    // Pack bytes into words (bytes past file end = 0xEE) and fill the expected queue.
    task automatic pack_file(int fsize, int doff);
        n_words = (fsize + 3) / 4;
        for (int k = 0; k < n_words; k++)
            for (int i = 0; i < 4; i++)
                words[k][31-8*i -: 8] = (4*k + i < fsize) ? fb[4*k+i] : 8'hEE;
        exp_q.delete();
        for (int p = doff; p < fsize; p += 4) begin
            logic [31:0] d;
            logic [2:0]  nb;
            d = '0;
            for (int i = 0; i < 4; i++)
                if (p + i < fsize) d[31-8*i -: 8] = fb[p+i];
            nb = (fsize - p >= 4) ? 3'd4 : 3'(fsize - p);
            exp_q.push_back({(p + 4 >= fsize), nb, d});
        end
        n_out = 0;
    endtask

    task automatic pulse_start();
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Driver: present words[0..n-1]; optional valid gaps; optional early stop after N output words.
    task automatic send_words(int n, bit gap, int stop_after);
        int idx = 0;
        int cyc = 0;
        while (idx < n && cyc < 2000) begin
            if (stop_after > 0 && n_out >= stop_after) break;
            in_valid = !(gap && (cyc % 3 == 1));
            in_data  = words[idx];
            @(negedge clk);
            if (in_valid && in_ready) idx++;
            @(posedge clk); #1;
            cyc++;
        end
        in_valid = 1'b0;
        if (cyc >= 2000) check_eq("send_timeout", 64'(idx), 64'(n));
    endtask

    task automatic wait_done(int budget);
        int c = 0;
        while (!done && c < budget) begin
            @(negedge clk);
            c++;
        end
        check_eq("done", done, 1);
    endtask

    task automatic check_zero_state(string tag);
        check_eq({tag, "_outs"}, {out_valid, out_last, out_nbytes, out_data, in_ready}, 0);
        check_eq({tag, "_fs_do"}, {file_size, data_offset}, 0);
        check_eq({tag, "_wh"}, {img_width, img_height}, 0);
        check_eq({tag, "_flags"}, {bit_count, hdr_valid, hdr_err, done}, 0);
    endtask

    // Output ready pattern 1,0,0,1 when toggling, else always ready.
    initial begin
        int ph = 0;
        forever begin
            @(posedge clk); #1;
            if (ready_toggle) begin
                out_ready = (ph == 0 || ph == 3);
                ph = (ph + 1) % 4;
            end else begin
                out_ready = 1'b1;
            end
        end
    end

    // Scoreboard: compare each handshaken word and check stability under stall.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_stall = 1'b0;
            end else begin
                if (out_valid) valid_seen++;
                if (prev_stall)
                    check_eq("stall_hold", {out_valid, out_last, out_nbytes, out_data}, {1'b1, prev_word});
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) check_eq("unexpected_word_qsize", 64'(exp_q.size()), 1);
                    else check_eq("out_word", {out_last, out_nbytes, out_data}, exp_q.pop_front());
                    if (n_out == 0) first_data = out_data;
                    last_data = out_data;
                    last_nb   = out_nbytes;
                    n_out++;
                end
                prev_stall = out_valid && !out_ready;
                prev_word  = {out_last, out_nbytes, out_data};
            end
        end
    end

    initial begin
        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_zero_state("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;

        // 1: 2x2 24bpp, payload starting in lane 2 of word 13.
        build_hdr(70, 54, 2, 2, 24);
        pack_file(70, 54);
        pulse_start();
        send_words(n_words, 1'b0, 0);
        wait_done(100);
        check_eq("t1_hdr_valid", {hdr_valid, hdr_err}, 2'b10);
        check_eq("t1_wh", {img_width, img_height}, {32'd2, 32'd2});
        check_eq("t1_bc", bit_count, 24);
        check_eq("t1_fs_do", {file_size, data_offset}, {32'd70, 32'd54});
        check_eq("t1_nout", n_out, 4);
        check_eq("t1_first", first_data, 32'h36373839);
        check_eq("t1_last", {last_nb, last_data}, {3'd4, 32'h42434445});
        check_eq("t1_qleft", exp_q.size(), 0);

        // 2: one extra byte 0xAB, leaves via FLUSH.
        build_hdr(71, 54, 2, 2, 24);
        fb[70] = 8'hAB;
        pack_file(71, 54);
        pulse_start();
        send_words(n_words, 1'b0, 0);
        wait_done(100);
        check_eq("t2_nout", n_out, 5);
        check_eq("t2_last", {last_nb, last_data}, {3'd1, 32'hAB000000});
        check_eq("t2_qleft", exp_q.size(), 0);

        // 3: bad signature.
        words[0] = 32'h424E4600;
        exp_q.delete();
        valid_seen = 0;
        pulse_start();
        send_words(1, 1'b0, 0);
        @(negedge clk);
        check_eq("t3_err", {hdr_err, hdr_valid, in_ready}, 3'b100);
        repeat (5) @(negedge clk);
        check_eq("t3_err_sticky", hdr_err, 1);
        check_eq("t3_no_output", valid_seen, 0);
        pulse_start();
        @(negedge clk);
        check_eq("t3_restart", {in_ready, hdr_err}, 2'b10);

        // 4: 32bpp with palette skip, continuing from the restart above.
        build_hdr(154, 138, 2, 2, 32);
        pack_file(154, 138);
        @(posedge clk); #1;
        send_words(n_words, 1'b0, 0);
        wait_done(100);
        check_eq("t4_hdr", {hdr_valid, bit_count, data_offset}, {1'b1, 16'd32, 32'd138});
        check_eq("t4_nout", n_out, 4);
        check_eq("t4_first", first_data, 32'h8A8B8C8D);
        check_eq("t4_last", {last_nb, last_data}, {3'd4, 32'h96979899});
        check_eq("t4_qleft", exp_q.size(), 0);

        // 5: gapped input with out_ready toggling 1,0,0,1.
        build_hdr(70, 54, 2, 2, 24);
        pack_file(70, 54);
        ready_toggle = 1'b1;
        pulse_start();
        send_words(n_words, 1'b1, 0);
        wait_done(200);
        ready_toggle = 1'b0;
        check_eq("t5_nout", n_out, 4);
        check_eq("t5_first", first_data, 32'h36373839);
        check_eq("t5_qleft", exp_q.size(), 0);

        // 6: reset after the second output word, then a clean rerun.
        build_hdr(70, 54, 2, 2, 24);
        pack_file(70, 54);
        pulse_start();
        send_words(n_words, 1'b0, 2);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check_eq("t6_nout_at_reset", n_out, 2);
        @(negedge clk);
        check_zero_state("t6_reset");
        pack_file(70, 54);
        pulse_start();
        send_words(n_words, 1'b0, 0);
        wait_done(100);
        check_eq("t6_nout", n_out, 4);
        check_eq("t6_first", first_data, 32'h36373839);
        check_eq("t6_last", {last_nb, last_data}, {3'd4, 32'h42434445});
        check_eq("t6_qleft", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
        $finish;
    end

endmodule
